// File: rtl/serial_arith_unit.sv
// Digit-serial signed add / sub / abs-sum / less-than unit, LSB-first, DIGIT bits per clock.
// One shared ripple digit adder serves both the arithmetic pass and the optional negate pass.
module serial_arith_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             lt,
  output logic             busy
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0]  OP_ABS = 2'b10;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH - 1){1'b0}}};

  if ((WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("serial_arith_unit: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, CALC, NEG, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               ovf_p_q, ovf_p_d;
  logic               ovf_q, ovf_d, lt_q, lt_d;
  logic               out_valid_q, out_valid_d;

  logic [DIGIT-1:0]       x_dig, y_dig, s_dig;
  logic                   c_msb, c_out;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic [WIDTH-1:0]       sum_nxt;
  logic                   last, v, ovf_calc, lt_calc;

  // One digit of ripple add; during NEG it adds ~sum + carry (carry seeded to 1).
  always_comb begin : digit_adder
    logic c;
    x_dig = a_q[DIGIT-1:0];
    y_dig = b_q[DIGIT-1:0];
    if (state_q == NEG) begin
      x_dig = ~sum_q[DIGIT-1:0];
      y_dig = '0;
    end
    s_dig = '0;
    c     = carry_q;
    c_msb = carry_q;
    for (int j = 0; j < int'(DIGIT); j++) begin
      c_msb    = c;
      s_dig[j] = x_dig[j] ^ y_dig[j] ^ c;
      c        = (x_dig[j] & y_dig[j]) | (c & (x_dig[j] ^ y_dig[j]));
    end
    c_out = c;
  end

  assign sum_cat  = {s_dig, sum_q};
  assign sum_nxt  = sum_cat[WIDTH+DIGIT-1:DIGIT];
  assign last     = (cnt_q == CNT_W'(N - 1));
  assign v        = c_msb ^ c_out;
  assign ovf_calc = v | ((op_q == OP_ABS) & (sum_nxt == MIN_VAL));
  assign lt_calc  = op_q[0] & (sum_nxt[WIDTH-1] ^ v);

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    ovf_p_d     = ovf_p_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    lt_d        = lt_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = op[0] ? ~B : B;
          op_d    = op;
          cnt_d   = '0;
          carry_d = op[0];
          state_d = CALC;
        end
      end
      CALC: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = sum_nxt;
        carry_d = c_out;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          cnt_d   = '0;
          ovf_p_d = ovf_calc;
          if ((op_q == OP_ABS) && sum_nxt[WIDTH-1]) begin
            carry_d = 1'b1;
            state_d = NEG;
          end else begin
            result_d    = sum_nxt;
            ovf_d       = ovf_calc;
            lt_d        = lt_calc;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      NEG: begin
        sum_d   = sum_nxt;
        carry_d = c_out;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          cnt_d       = '0;
          result_d    = sum_nxt;
          ovf_d       = ovf_p_q;
          lt_d        = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      ovf_p_q     <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      lt_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      ovf_p_q     <= ovf_p_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      lt_q        <= lt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign lt        = lt_q;

endmodule

// File: tb/tb_serial_arith_unit.sv
// Directed-vector bench for serial_arith_unit (8/2) plus exhaustive 5-bit sweeps
// on DIGIT=1 and DIGIT=5 instances against an integer reference model.
module tb_serial_arith_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, ovf, lt, busy;
  logic [1:0] op;
  logic [7:0] a_s, b_s, result;

  logic       w_in_valid, w_out_ready;
  logic [1:0] w_op;
  logic [4:0] w_a, w_b, d1_result, d5_result;
  logic       d1_in_ready, d1_out_valid, d1_ovf, d1_lt, d1_busy;
  logic       d5_in_ready, d5_out_valid, d5_ovf, d5_lt, d5_busy;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  serial_arith_unit #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .A(a_s), .B(b_s), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .lt(lt), .busy(busy));

  serial_arith_unit #(.WIDTH(5), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(d1_in_ready), .op(w_op),
    .A(w_a), .B(w_b), .out_valid(d1_out_valid), .out_ready(w_out_ready),
    .result(d1_result), .ovf(d1_ovf), .lt(d1_lt), .busy(d1_busy));

  serial_arith_unit #(.WIDTH(5), .DIGIT(5)) u_d5 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(d5_in_ready), .op(w_op),
    .A(w_a), .B(w_b), .out_valid(d5_out_valid), .out_ready(w_out_ready),
    .result(d5_result), .ovf(d5_ovf), .lt(d5_lt), .busy(d5_busy));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op on the 8-bit unit from a negedge, wait for out_valid, then complete the handshake.
  task automatic do_op(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                       output logic [7:0] r, output logic f_ovf, output logic f_lt, output int lat);
    in_valid = 1'b1; op = o; a_s = av; b_s = bv;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 40);
    r = result; f_ovf = ovf; f_lt = lt;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic void ref5(input logic [1:0] o, input logic [4:0] a, input logic [4:0] b,
                               output logic [4:0] r, output logic v, output logic l, output logic neg);
    int sa, sb, s, ws;
    logic [4:0] w;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    s   = o[0] ? sa - sb : sa + sb;
    w   = 5'(s);
    v   = (s > 15) || (s < -16);
    l   = 1'b0;
    neg = 1'b0;
    r   = w;
    if (o[0]) l = (sa < sb);
    if (o == 2'b10) begin
      ws  = int'($signed(w));
      neg = (ws < 0);
      r   = 5'(neg ? -ws : ws);
      v   = v || (ws == -16);
    end
  endfunction

  typedef struct {
    logic [1:0] op;
    logic [7:0] a, b, res;
    logic       ovf, lt;
    int         lat;
  } vec_t;

  initial begin
    vec_t       vecs [14];
    logic [7:0] r;
    logic       f_ovf, f_lt, got1, got5, neg;
    logic [4:0] er, r1, r5;
    logic       ev, el, o1, o5, l1, l5;
    int         lat, cyc, lat1, lat5;

    vecs[0]  = '{2'b00, 8'h64, 8'h32, 8'h96, 1'b1, 1'b0, 5};
    vecs[1]  = '{2'b01, 8'h05, 8'h0A, 8'hFB, 1'b0, 1'b1, 5};
    vecs[2]  = '{2'b11, 8'h7F, 8'h80, 8'hFF, 1'b1, 1'b0, 5};
    vecs[3]  = '{2'b10, 8'hF0, 8'hF8, 8'h18, 1'b0, 1'b0, 9};
    vecs[4]  = '{2'b10, 8'h10, 8'h08, 8'h18, 1'b0, 1'b0, 5};
    vecs[5]  = '{2'b10, 8'h80, 8'h00, 8'h80, 1'b1, 1'b0, 9};
    vecs[6]  = '{2'b00, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 5};
    vecs[7]  = '{2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 5};
    vecs[8]  = '{2'b11, 8'h03, 8'h03, 8'h00, 1'b0, 1'b0, 5};
    vecs[9]  = '{2'b10, 8'h7F, 8'h7F, 8'h02, 1'b1, 1'b0, 9};
    vecs[10] = '{2'b10, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 5};
    vecs[11] = '{2'b00, 8'h80, 8'hFF, 8'h7F, 1'b1, 1'b0, 5};
    vecs[12] = '{2'b11, 8'hFE, 8'h02, 8'hFC, 1'b0, 1'b1, 5};
    vecs[13] = '{2'b10, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 9};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a_s = '0; b_s = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_op = '0; w_a = '0; w_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset lt", 32'(lt), 32'd0);

    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, f_ovf, f_lt, lat);
      check($sformatf("v%0d result", i), 32'(r), 32'(vecs[i].res));
      check($sformatf("v%0d ovf", i), 32'(f_ovf), 32'(vecs[i].ovf));
      check($sformatf("v%0d lt", i), 32'(f_lt), 32'(vecs[i].lt));
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d in_ready after handshake", i), 32'(in_ready), 32'd1);
      check($sformatf("v%0d out_valid after handshake", i), 32'(out_valid), 32'd0);
    end

    // Backpressure: DONE holds while new operands wait on in_valid.
    in_valid = 1'b1; op = 2'b00; a_s = 8'h64; b_s = 8'h32;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 40);
    check("bp latency", 32'(lat), 32'd5);
    in_valid = 1'b1; op = 2'b00; a_s = 8'h11; b_s = 8'h22;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d result", k), 32'(result), 32'h96);
      check($sformatf("bp%0d ovf", k), 32'(ovf), 32'd1);
      check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release in_ready", 32'(in_ready), 32'd1);
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release result held", 32'(result), 32'h96);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 40);
    check("bp new op latency", 32'(lat), 32'd5);
    check("bp new op result", 32'(result), 32'h33);
    check("bp new op ovf", 32'(ovf), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during CALC digit 2 discards the op and clears the output registers.
    do_op(2'b01, 8'h05, 8'h0A, r, f_ovf, f_lt, lat);
    check("pre-reset lt", 32'(f_lt), 32'd1);
    in_valid = 1'b1; op = 2'b01; a_s = 8'h05; b_s = 8'h0A;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid-op busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid-reset in_ready", 32'(in_ready), 32'd1);
    check("mid-reset out_valid", 32'(out_valid), 32'd0);
    check("mid-reset result", 32'(result), 32'd0);
    check("mid-reset ovf", 32'(ovf), 32'd0);
    check("mid-reset lt", 32'(lt), 32'd0);
    do_op(2'b00, 8'h01, 8'h01, r, f_ovf, f_lt, lat);
    check("post-reset add result", 32'(r), 32'h02);
    check("post-reset add latency", 32'(lat), 32'd5);

    // Exhaustive 5-bit sweep, both instances driven in lockstep.
    for (int o = 0; o < 4; o++) begin
      for (int a = 0; a < 32; a++) begin
        for (int b = 0; b < 32; b++) begin
          ref5(2'(o), 5'(a), 5'(b), er, ev, el, neg);
          w_in_valid = 1'b1; w_op = 2'(o); w_a = 5'(a); w_b = 5'(b);
          got1 = 1'b0; got5 = 1'b0; cyc = 0; lat1 = 0; lat5 = 0;
          r1 = '0; r5 = '0; o1 = 1'b0; o5 = 1'b0; l1 = 1'b0; l5 = 1'b0;
          while (!(got1 && got5) && cyc < 20) begin
            @(negedge clk);
            w_in_valid = 1'b0;
            cyc++;
            if (!got1 && d1_out_valid) begin
              got1 = 1'b1; lat1 = cyc; r1 = d1_result; o1 = d1_ovf; l1 = d1_lt;
            end
            if (!got5 && d5_out_valid) begin
              got5 = 1'b1; lat5 = cyc; r5 = d5_result; o5 = d5_ovf; l5 = d5_lt;
            end
          end
          check($sformatf("d1 op%0d a%0h b%0h result", o, a, b), 32'(r1), 32'(er));
          check($sformatf("d1 op%0d a%0h b%0h ovf", o, a, b), 32'(o1), 32'(ev));
          check($sformatf("d1 op%0d a%0h b%0h lt", o, a, b), 32'(l1), 32'(el));
          check($sformatf("d1 op%0d a%0h b%0h latency", o, a, b), 32'(lat1), neg ? 32'd11 : 32'd6);
          check($sformatf("d5 op%0d a%0h b%0h result", o, a, b), 32'(r5), 32'(er));
          check($sformatf("d5 op%0d a%0h b%0h ovf", o, a, b), 32'(o5), 32'(ev));
          check($sformatf("d5 op%0d a%0h b%0h lt", o, a, b), 32'(l5), 32'(el));
          check($sformatf("d5 op%0d a%0h b%0h latency", o, a, b), 32'(lat5), neg ? 32'd3 : 32'd2);
          w_out_ready = 1'b1;
          @(negedge clk);
          w_out_ready = 1'b0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
